// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the multicycle signed multiply/divide unit:
//   - DATA_W / CNT_W : operand width and iteration-counter width
//   - OP_MULT/OP_DIV : encodings of the op select input
//   - state_e        : control FSM states
//   - negate/abs_val : two's-complement helpers used by the divide path
// -----------------------------------------------------------------------------
package mult_div_pkg;

    localparam int DATA_W = 32;
    // Must be able to hold the value DATA_W itself.
    localparam int CNT_W  = $clog2(DATA_W) + 1;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Two's-complement negation (wraps for the most negative value).
    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude as an unsigned DATA_W value; the most negative input maps to
    // 2^(DATA_W-1), which still fits unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? negate(v) : v;
    endfunction

endpackage

// File: rtl/mult_div_if.sv
// -----------------------------------------------------------------------------
// mult_div_if
// Bundle between Control/datapath (master) and the multiply/divide unit (slave).
//   start, op, a_in, b_in    : request (master -> unit)
//   busy, done, div_zero     : status  (unit -> master)
//   hi, lo                   : architectural HI/LO registers (unit -> master)
// -----------------------------------------------------------------------------
interface mult_div_if;
    import mult_div_pkg::*;

    logic              start;
    logic              op;
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              busy;
    logic              done;
    logic              div_zero;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multicycle signed multiply (radix-2 Booth) / divide (restoring, on
// magnitudes, sign-fixed afterwards) with architectural HI/LO registers.
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : asynchronous active-high reset, clears all state and outputs
//   bus    : mult_div_if.slave (start/op/a_in/b_in in; busy/done/div_zero/hi/lo out)
// Latency from the edge that accepts start: MULT 33 edges, DIV 34 edges,
// DIV by zero 1 edge. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    mult_div_if.slave  bus
);

    // Working registers. acc is one bit wider than an operand so the Booth
    // subtract of the most negative multiplicand cannot overflow; in DIV it
    // holds the partial remainder.
    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [DATA_W:0]    acc_q,      acc_d;      // Booth acc / remainder
    logic [DATA_W-1:0]  mq_q,       mq_d;       // multiplier -> product low / dividend -> quotient
    logic               q1_q,       q1_d;       // Booth q-1 bit
    logic [DATA_W-1:0]  mcand_q,    mcand_d;    // multiplicand / divisor magnitude
    logic               a_neg_q,    a_neg_d;
    logic               b_neg_q,    b_neg_d;
    logic               dz_q,       dz_d;       // pending divide-by-zero
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               div_zero_q, div_zero_d;
    logic [DATA_W-1:0]  hi_q,       hi_d;
    logic [DATA_W-1:0]  lo_q,       lo_d;

    logic [DATA_W:0]    booth_acc_s;
    logic [DATA_W:0]    trial_s;
    logic [DATA_W:0]    diff_s;

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    // Next-state and datapath logic for the control FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mq_d        = mq_q;
        q1_d        = q1_q;
        mcand_d     = mcand_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        dz_d        = dz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        booth_acc_s = acc_q;

        // Restoring step: shift the next dividend bit into the remainder and
        // try to subtract the divisor; a negative difference means restore.
        trial_s = {acc_q[DATA_W-1:0], mq_q[DATA_W-1]};
        diff_s  = trial_s - {1'b0, mcand_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_sel_load();
                end else begin
                    busy_d = 1'b0;
                end
            end

            MULT: begin
                case ({mq_q[0], q1_q})
                    2'b01:   booth_acc_s = acc_q + {mcand_q[DATA_W-1], mcand_q};
                    2'b10:   booth_acc_s = acc_q - {mcand_q[DATA_W-1], mcand_q};
                    default: booth_acc_s = acc_q;
                endcase
                // Arithmetic right shift of {acc, multiplier, q-1}.
                {acc_d, mq_d, q1_d} = {booth_acc_s[DATA_W], booth_acc_s, mq_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = MULT;
                end
            end

            DIV: begin
                if (diff_s[DATA_W]) begin
                    acc_d = trial_s;
                end else begin
                    acc_d = diff_s;
                end
                mq_d  = {mq_q[DATA_W-2:0], ~diff_s[DATA_W]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end else begin
                    state_d = DIV;
                end
            end

            FIX: begin
                // Quotient truncates toward zero; remainder follows dividend sign.
                if (a_neg_q ^ b_neg_q) begin
                    mq_d = negate(mq_q);
                end else begin
                    mq_d = mq_q;
                end
                if (a_neg_q) begin
                    acc_d = {1'b0, negate(acc_q[DATA_W-1:0])};
                end else begin
                    acc_d = {1'b0, acc_q[DATA_W-1:0]};
                end
                state_d = DONE;
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = {CNT_W{1'b0}};
                dz_d    = 1'b0;
                state_d = IDLE;
                if (dz_q) begin
                    // HI/LO are left untouched on divide by zero.
                    div_zero_d = 1'b1;
                end else begin
                    hi_d = acc_q[DATA_W-1:0];
                    lo_d = mq_q;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Start-of-operation load: latch operands and select the first state.
    function automatic void op_sel_load();
        busy_d  = 1'b1;
        a_neg_d = bus.a_in[DATA_W-1];
        b_neg_d = bus.b_in[DATA_W-1];
        cnt_d   = CNT_W'(DATA_W);
        acc_d   = {(DATA_W+1){1'b0}};
        q1_d    = 1'b0;
        dz_d    = 1'b0;
        if (bus.op == OP_MULT) begin
            mq_d    = bus.b_in;
            mcand_d = bus.a_in;
            state_d = MULT;
        end else if (bus.b_in == {DATA_W{1'b0}}) begin
            // No iterations: report straight from DONE.
            mq_d    = {DATA_W{1'b0}};
            mcand_d = {DATA_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            dz_d    = 1'b1;
            state_d = DONE;
        end else begin
            mq_d    = abs_val(bus.a_in);
            mcand_d = abs_val(bus.b_in);
            state_d = DIV;
        end
    endfunction

    // State, working and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {(DATA_W+1){1'b0}};
            mq_q       <= {DATA_W{1'b0}};
            q1_q       <= 1'b0;
            mcand_q    <= {DATA_W{1'b0}};
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {DATA_W{1'b0}};
            lo_q       <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mq_q       <= mq_d;
            q1_q       <= q1_d;
            mcand_q    <= mcand_d;
            a_neg_q    <= a_neg_d;
            b_neg_q    <= b_neg_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Table-driven bench for mult_div_unit: each record holds an operation, its
// operands and the hand-computed HI/LO/div_zero/latency. Extra hand-written
// sequences cover start-while-busy and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;
    import mult_div_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mult_div_if bus_if ();

    mult_div_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation (called at posedge+1), optionally re-pulse start
    // with a DIV 9/3 on edge glitch_at after acceptance; returns the number
    // of edges from acceptance to done (0 on timeout).
    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at, output int lat);
        lat = 0;
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a_in  = a;
        bus_if.b_in  = b;
        @(posedge clk); #1;
        check("busy_after_start", {31'd0, bus_if.busy}, 32'd1);
        check("done_cleared", {31'd0, bus_if.done}, 32'd0);
        check("dz_cleared", {31'd0, bus_if.div_zero}, 32'd0);
        bus_if.start = 1'b0;
        bus_if.op    = ~op;
        bus_if.a_in  = $urandom;
        bus_if.b_in  = $urandom;
        for (int n = 1; n <= 40; n++) begin
            if (n == glitch_at) begin
                bus_if.start = 1'b1;
                bus_if.op    = OP_DIV;
                bus_if.a_in  = 32'd9;
                bus_if.b_in  = 32'd3;
            end
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            if (bus_if.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=none expected=done within 40 edges");
        end
    endtask

    task automatic check_result(input string tag, input vec_t v, input int lat);
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_hi"}, bus_if.hi, v.exp_hi);
        check({tag, "_lo"}, bus_if.lo, v.exp_lo);
        check({tag, "_div_zero"}, {31'd0, bus_if.div_zero}, {31'd0, v.exp_dz});
        check({tag, "_busy_at_done"}, {31'd0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        int   lat;
        vec_t v;
        checks = 0;
        errors = 0;

        //          op       a             b             hi            lo            dz    lat
        vecs.push_back('{OP_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33});
        vecs.push_back('{OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33});
        vecs.push_back('{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33});
        vecs.push_back('{OP_MULT, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33});
        vecs.push_back('{OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33});
        vecs.push_back('{OP_MULT, 32'd0,        32'd12345,    32'h00000000, 32'h00000000, 1'b0, 33});
        vecs.push_back('{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34});
        vecs.push_back('{OP_DIV,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34});
        vecs.push_back('{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34});
        vecs.push_back('{OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0, 34});
        vecs.push_back('{OP_DIV,  32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022, 1'b0, 34});
        // Divide by zero right after hi=0x11/lo=0x22: registers must hold.
        vecs.push_back('{OP_DIV,  32'd5,        32'd0,        32'h00000011, 32'h00000022, 1'b1, 1});

        bus_if.start = 1'b0;
        bus_if.op    = OP_MULT;
        bus_if.a_in  = 32'd0;
        bus_if.b_in  = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("rst_done", {31'd0, bus_if.done}, 32'd0);
        check("rst_div_zero", {31'd0, bus_if.div_zero}, 32'd0);
        check("rst_hi", bus_if.hi, 32'd0);
        check("rst_lo", bus_if.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op(v.op, v.a, v.b, 0, lat);
            check_result($sformatf("vec%0d", i), v, lat);
        end

        // Start while busy is ignored: MULT 3x4 with a DIV 9/3 strobe at k+5.
        v = '{OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33};
        run_op(v.op, v.a, v.b, 5, lat);
        check_result("busy_ignore", v, lat);
        // Back-to-back DIV 9/3 on the edge after done.
        v = '{OP_DIV, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 34};
        run_op(v.op, v.a, v.b, 0, lat);
        check_result("back_to_back", v, lat);

        // Reset at k+10 of a MULT: aborts at once, clears HI/LO, no done.
        bus_if.start = 1'b1;
        bus_if.op    = OP_MULT;
        bus_if.a_in  = 32'd7;
        bus_if.b_in  = 32'd9;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, bus_if.busy}, 32'd0);
        check("abort_hi", bus_if.hi, 32'd0);
        check("abort_lo", bus_if.lo, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus_if.done === 1'b1) begin
                break;
            end
        end
        check("abort_no_done", {31'd0, bus_if.done}, 32'd0);
        check("abort_still_idle", {31'd0, bus_if.busy}, 32'd0);
        v = '{OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33};
        run_op(v.op, v.a, v.b, 0, lat);
        check_result("after_reset", v, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multicycle signed multiply/divide unit with architectural HI/LO registers for the multicycle MIPS datapath. It sits beside the ALU: it takes operands from the A/B register outputs on a start strobe from Control. It drives HI/LO into the register write-data mux for mfhi/mflo. It reports busy/done to Control and raises a divide-by-zero flag that feeds Control's exception input.

## Interface
- DATA_W, 32, operand width; HI/LO are DATA_W each, product is 2*DATA_W
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  one-cycle strobe from Control; sampled only in IDLE
- op  in  1  0 = MULT, 1 = DIV; sampled with start
- a_in  in  DATA_W  signed operand (multiplicand / dividend), from A register
- b_in  in  DATA_W  signed operand (multiplier / divisor), from B register
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; HI/LO valid from this cycle
- div_zero  out  1  one-cycle pulse, coincident with done, on DIV with b_in = 0
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

## Operation
- States: IDLE, MULT, DIV, FIX, DONE.
- IDLE:
  - On start=1, latch a_in, b_in and op.
  - Load the iteration counter with DATA_W.
  - Go to MULT or DIV.
  - DIV with b_in=0 goes straight to DONE with div_zero set.
- MULT: radix-2 Booth.
  - One step per cycle on the {acc, multiplier, q-1} register, using an arithmetic right shift.
  - After DATA_W steps go to DONE: hi ← product[63:32], lo ← product[31:0].
- DIV: restoring divide on operand magnitudes.
  - One quotient bit per cycle.
  - After DATA_W steps go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - Result: quotient truncates toward zero; remainder takes the dividend's sign.
  - lo ← quotient, hi ← remainder. Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Divide by zero: hi/lo unchanged, div_zero=1 with done. No iterations run.
- Overflow case -2^31 / -1: lo=0x80000000, hi=0. This is the wrapped result; no flag is raised.
- start while busy is ignored. op/a_in/b_in changes after the start edge have no effect.
- hi/lo hold their value between operations.
- The unit never writes the register file; Control selects hi/lo via WD_REG.

## Timing
- Reset values:
  - busy=0, done=0, div_zero=0, hi=0, lo=0.
  - State is IDLE; counter and working registers are 0.
- Let edge k sample start=1 in IDLE. busy=1 after edge k.
- MULT: iterations on edges k+1..k+32.
  - The edge that writes hi/lo also raises done: k+33.
  - busy falls at that same edge.
- DIV: iterations on k+1..k+32, FIX at k+33, done/hi/lo at k+34.
- DIV by zero: done=div_zero=1 after edge k+1; busy falls at k+1.
- done and div_zero last exactly one cycle.
- A new start is accepted on the edge after done (back-to-back issue).
- Reset asserted mid-operation:
  - Aborts immediately, asynchronously.
  - hi/lo return to 0 and no done is produced.
  - The first start after deassertion behaves as from power-up.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package mult_div_pkg:
  - state enum (IDLE, MULT, DIV, FIX, DONE);
  - OP_MULT=1'b0 and OP_DIV=1'b1 constants;
  - DATA_W default;
  - abs/negate helper functions.
- Single module mult_div_unit.
- Control FSM and datapath share one always block pair: sequential plus next-state.
- Optional sub-module: div_core, holding the restoring step and sign fix, so the same counter/FSM serves both ops. No separate multiplier module.

## Test plan
- MULT 7 × -3: start at edge k → done after k+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low same edge.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000. Then MULT 0xFFFFFFFF × 0xFFFFFFFF → hi=0, lo=1.
- DIV -7 / 2 → done after k+34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Prior hi=0x11, lo=0x22, then DIV 5 / 0 → done=div_zero=1 after k+1 for one cycle, hi=0x11 and lo=0x22 unchanged.
- Start MULT 3×4, pulse start with DIV 9/3 at k+5 → second strobe ignored, result hi=0, lo=12. Issue DIV 9/3 on the edge after done → lo=3, hi=0.
- Reset asserted at k+10 of a MULT → busy=0, hi=lo=0 immediately, no done. A start after release gives the correct result at the +33 latency.
